// File: rtl/counter_down_reload.sv
// Reloadable down counter / countdown timer with a one-cycle terminal-count
// pulse. Counts down on enabled cycles while running; at terminal count it
// either reloads the stored start value (AUTO=1) or stops at zero (AUTO=0).
module counter_down_reload #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENA,
  input  logic             LOAD,
  input  logic             AUTO,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             ZERO,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  state_t           state_q, state_next;
  logic [WIDTH-1:0] count_q, count_next;
  logic [WIDTH-1:0] reload_q, reload_next;
  logic             tc_q, tc_next;

  // State, count, reload value and terminal pulse registers; reset has priority
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_next;
      count_q  <= count_next;
      reload_q <= reload_next;
      tc_q     <= tc_next;
    end
  end

  // Next-state and datapath: LOAD beats decrement; only RUN with ENA counts
  always_comb begin
    state_next  = state_q;
    count_next  = count_q;
    reload_next = reload_q;
    tc_next     = 1'b0;
    if (LOAD) begin
      count_next  = DATA;
      reload_next = DATA;
      state_next  = (DATA != '0) ? RUN : IDLE;
    end else if (state_q == RUN && ENA) begin
      if (count_q == WIDTH'(1)) begin
        tc_next = 1'b1;
        if (AUTO) begin
          count_next = reload_q;
        end else begin
          count_next = '0;
          state_next = EXPIRED;
        end
      end else if (count_q != '0) begin
        count_next = count_q - WIDTH'(1);
      end
    end
  end

  // Outputs: BUSY from state, ZERO straight from the count register
  always_comb begin
    COUNT = count_q;
    TC    = tc_q;
    BUSY  = (state_q == RUN);
    ZERO  = (count_q == '0);
  end

endmodule
